// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the convolution layer sequencer.
package conv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int BANKS      = 4;
  localparam int BANK_W     = 2;
  localparam int OUT_ADDR_W = 10;
  localparam int CFG_WORDS  = 4;
  localparam int REG_ADDR_W = 2;
  localparam int WORDS_W    = 11;
  localparam int GROUPS_W   = 8;
  localparam int TIMEOUT_W  = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ADDR_CFG0 = 2'd0;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_CFG1 = 2'd1;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_CFG2 = 2'd2;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_CFG3 = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_RST  = 4'd1,
    ST_CFG       = 4'd2,
    ST_LOAD_IN   = 4'd3,
    ST_LOAD_K    = 4'd4,
    ST_RUN       = 4'd5,
    ST_DRAIN_RD  = 4'd6,
    ST_DRAIN_OUT = 4'd7,
    ST_NEXT      = 4'd8,
    ST_DONE      = 4'd9
  } state_t;

  // Words per bank: zero means one, anything past the BRAM depth is clipped.
  function automatic logic [WORDS_W-1:0] clamp_words(input logic [WORDS_W-1:0] w);
    if (w == '0) return WORDS_W'(1);
    if (w > WORDS_W'(1024)) return WORDS_W'(1024);
    return w;
  endfunction
endpackage

// File: rtl/conv_drain_unit.sv
// Output BRAM drain: bank/word address counters and the result stream register.
module conv_drain_unit import conv_pkg::*; (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              drain_rd,
  input  logic                              drain_out,
  input  logic [WORDS_W-1:0]                words,
  input  logic [BANKS-1:0][DATA_WIDTH-1:0]  bram_data,
  input  logic                              ready,
  output logic [BANKS-1:0]                  renable,
  output logic [OUT_ADDR_W-1:0]             raddr,
  output logic                              valid,
  output logic [DATA_WIDTH-1:0]             data,
  output logic                              last,
  output logic                              fire
);
  logic [BANK_W-1:0]     bank_cnt;
  logic [WORDS_W-1:0]    word_cnt;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  end_of_bank;
  logic                  end_of_group;

  assign end_of_bank  = (word_cnt == words - WORDS_W'(1));
  assign end_of_group = end_of_bank && (bank_cnt == BANK_W'(BANKS - 1));

  assign renable = drain_rd ? ({{(BANKS-1){1'b0}}, 1'b1} << bank_cnt) : '0;
  assign raddr   = drain_rd ? word_cnt[OUT_ADDR_W-1:0] : '0;
  assign valid   = valid_q;
  assign data    = data_q;
  assign last    = valid_q && end_of_group;
  assign fire    = valid_q && ready;

  // The first DRAIN_OUT cycle is the one where the BRAM read data is valid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bank_cnt <= '0;
      word_cnt <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (drain_out && !valid_q) begin
      valid_q <= 1'b1;
      data_q  <= bram_data[bank_cnt];
    end else if (fire) begin
      valid_q <= 1'b0;
      if (end_of_bank) begin
        word_cnt <= '0;
        bank_cnt <= bank_cnt + BANK_W'(1);
      end else begin
        word_cnt <= word_cnt + WORDS_W'(1);
      end
    end
  end
endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer: configures the core, runs each filter group, drains results.
// Stream handshake: a word transfers on a rising edge where o_m_valid and i_m_ready are both high; o_m_data/o_m_last hold while o_m_valid waits.
module conv_layer_sequencer import conv_pkg::*; (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              i_start,
  input  logic [GROUPS_W-1:0]               i_num_groups,
  input  logic [WORDS_W-1:0]                i_out_words,
  input  logic [TIMEOUT_W-1:0]              i_timeout,
  input  logic [CFG_WORDS-1:0][DATA_WIDTH-1:0] i_cfg,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  input  logic                              i_core_reset_busy,
  input  logic                              i_core_done,
  output logic                              o_core_enable,
  output logic                              o_input_start,
  output logic                              o_kernel_start,
  output logic                              o_load_new_filter,
  output logic                              o_reg_wen,
  output logic [REG_ADDR_W-1:0]             o_reg_waddr,
  output logic [DATA_WIDTH-1:0]             o_reg_wdata,
  output logic [BANKS-1:0]                  o_renable,
  output logic [OUT_ADDR_W-1:0]             o_raddr,
  input  logic [BANKS-1:0][DATA_WIDTH-1:0]  i_bram_data,
  output logic                              o_m_valid,
  output logic [DATA_WIDTH-1:0]             o_m_data,
  output logic                              o_m_last,
  input  logic                              i_m_ready,
  output state_t                            o_state
);
  state_t state, state_nxt;

  logic [GROUPS_W-1:0]               groups_q;
  logic [WORDS_W-1:0]                words_q;
  logic [TIMEOUT_W-1:0]              timeout_q;
  logic [CFG_WORDS-1:0][DATA_WIDTH-1:0] cfg_q;
  logic [REG_ADDR_W-1:0]             cfg_idx;
  logic [TIMEOUT_W-1:0]              run_cnt;
  logic [GROUPS_W-1:0]               grp_cnt;
  logic                              error_q;
  logic                              wd_expire;
  logic                              groups_left;
  logic                              drain_fire;
  logic                              drain_last;

  assign wd_expire   = (state == ST_RUN) && (timeout_q != '0) &&
                       (run_cnt == timeout_q - TIMEOUT_W'(1));
  assign groups_left = ({1'b0, grp_cnt} + 9'd1) < {1'b0, groups_q};
  assign o_error     = error_q;
  assign o_state     = state;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (i_start) state_nxt = ST_WAIT_RST;
      ST_WAIT_RST:  if (!i_core_reset_busy) state_nxt = ST_CFG;
      ST_CFG:       if (cfg_idx == REG_ADDR_W'(CFG_WORDS - 1)) state_nxt = ST_LOAD_IN;
      ST_LOAD_IN:   state_nxt = ST_LOAD_K;
      ST_LOAD_K:    state_nxt = ST_RUN;
      // Core completion takes priority over a watchdog expiring in the same cycle.
      ST_RUN: begin
        if (i_core_done)    state_nxt = ST_DRAIN_RD;
        else if (wd_expire) state_nxt = ST_DONE;
      end
      ST_DRAIN_RD:  state_nxt = ST_DRAIN_OUT;
      ST_DRAIN_OUT: if (drain_fire) state_nxt = drain_last ? ST_NEXT : ST_DRAIN_RD;
      ST_NEXT:      state_nxt = groups_left ? ST_LOAD_K : ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy            = (state != ST_IDLE);
    o_done            = 1'b0;
    o_core_enable     = 1'b0;
    o_input_start     = 1'b0;
    o_kernel_start    = 1'b0;
    o_load_new_filter = 1'b0;
    o_reg_wen         = 1'b0;
    o_reg_waddr       = '0;
    o_reg_wdata       = '0;
    case (state)
      ST_CFG: begin
        o_reg_wen   = 1'b1;
        o_reg_waddr = cfg_idx;
        o_reg_wdata = cfg_q[cfg_idx];
      end
      ST_LOAD_IN: o_input_start = 1'b1;
      ST_LOAD_K: begin
        o_kernel_start    = 1'b1;
        o_load_new_filter = 1'b1;
      end
      ST_RUN:  o_core_enable = 1'b1;
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      groups_q  <= '0;
      words_q   <= '0;
      timeout_q <= '0;
      cfg_q     <= '0;
      cfg_idx   <= '0;
      run_cnt   <= '0;
      grp_cnt   <= '0;
      error_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        groups_q  <= (i_num_groups == '0) ? GROUPS_W'(1) : i_num_groups;
        words_q   <= clamp_words(i_out_words);
        timeout_q <= i_timeout;
        cfg_q     <= i_cfg;
        cfg_idx   <= '0;
        grp_cnt   <= '0;
        error_q   <= 1'b0;
      end
      if (state == ST_CFG) cfg_idx <= cfg_idx + REG_ADDR_W'(1);
      run_cnt <= (state == ST_RUN) ? run_cnt + TIMEOUT_W'(1) : '0;
      if (wd_expire && !i_core_done) error_q <= 1'b1;
      if (state == ST_NEXT) grp_cnt <= grp_cnt + GROUPS_W'(1);
    end
  end

  conv_drain_unit u_drain (
    .clk       (clk),
    .resetn    (resetn),
    .drain_rd  (state == ST_DRAIN_RD),
    .drain_out (state == ST_DRAIN_OUT),
    .words     (words_q),
    .bram_data (i_bram_data),
    .ready     (i_m_ready),
    .renable   (o_renable),
    .raddr     (o_raddr),
    .valid     (o_m_valid),
    .data      (o_m_data),
    .last      (drain_last),
    .fire      (drain_fire)
  );
  assign o_m_last = drain_last;
endmodule
